bank_biu_linefill: RTL and testbench

BANK_BIU_LINEFILL -- requirements
Module: bank_biu_linefill

---
 rtl/bank_biu_pkg.sv | 26 ++
 rtl/bank_biu_linefill_if.sv | 51 +++++
 rtl/bank_biu_req_fifo.sv | 46 ++++
 rtl/bank_biu_linefill.sv | 111 +++++++++++
 tb/tb_bank_biu_linefill.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_biu_pkg.sv
// Shared widths, request record and return-FSM encoding for the linefill BIU.
package bank_biu_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 128;
    localparam int ID_W   = 6;
    localparam logic [7:0] AR_LEN = 8'd1;

    typedef enum logic [1:0] {
        RET_BEAT0 = 2'd0,
        RET_BEAT1 = 2'd1,
        RET_OUT   = 2'd2
    } ret_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  set;
        logic [2:0]  way;
    } fill_req_t;

    // The memory ID doubles as the cache destination so returns need no lookup.
    function automatic logic [ID_W-1:0] make_id(input logic [2:0] set, input logic [2:0] way);
        return {set, way};
    endfunction

endpackage

// File: rtl/bank_biu_linefill_if.sv
// Request, AXI-style read and ISU line-return signals of the linefill BIU.
interface bank_biu_linefill_if;

    logic         htu_biu_req_valid_i;
    logic         htu_biu_req_ready_o;
    logic [2:0]   htu_biu_req_set_i;
    logic [2:0]   htu_biu_req_way_i;
    logic [31:0]  htu_biu_req_addr_i;

    logic         biu_mem_arvalid_o;
    logic         biu_mem_arready_i;
    logic [31:0]  biu_mem_araddr_o;
    logic [5:0]   biu_mem_arid_o;
    logic [7:0]   biu_mem_arlen_o;

    logic         mem_biu_rvalid_i;
    logic         mem_biu_rready_o;
    logic [127:0] mem_biu_rdata_i;
    logic [5:0]   mem_biu_rid_i;
    logic         mem_biu_rlast_i;

    logic         biu_isu_rvalid_o;
    logic         biu_isu_rready_i;
    logic [255:0] biu_isu_rdata_o;
    logic [5:0]   biu_isu_rid_o;
    logic         biu_err_o;

    // The BIU itself sits on the slave side of this bundle.
    modport slave (
        input  htu_biu_req_valid_i, htu_biu_req_set_i, htu_biu_req_way_i, htu_biu_req_addr_i,
        output htu_biu_req_ready_o,
        output biu_mem_arvalid_o, biu_mem_araddr_o, biu_mem_arid_o, biu_mem_arlen_o,
        input  biu_mem_arready_i,
        input  mem_biu_rvalid_i, mem_biu_rdata_i, mem_biu_rid_i, mem_biu_rlast_i,
        output mem_biu_rready_o,
        output biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o, biu_err_o,
        input  biu_isu_rready_i
    );

    modport master (
        output htu_biu_req_valid_i, htu_biu_req_set_i, htu_biu_req_way_i, htu_biu_req_addr_i,
        input  htu_biu_req_ready_o,
        input  biu_mem_arvalid_o, biu_mem_araddr_o, biu_mem_arid_o, biu_mem_arlen_o,
        output biu_mem_arready_i,
        output mem_biu_rvalid_i, mem_biu_rdata_i, mem_biu_rid_i, mem_biu_rlast_i,
        input  mem_biu_rready_o,
        input  biu_isu_rvalid_o, biu_isu_rdata_o, biu_isu_rid_o, biu_err_o,
        output biu_isu_rready_i
    );

endinterface

// File: rtl/bank_biu_req_fifo.sv
// Linefill request queue; head entry is presented combinationally for the AR channel.
module bank_biu_req_fifo
    import bank_biu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  fill_req_t push_data,
    input  logic      pop,
    output fill_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    fill_req_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit tells a full queue from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bank_biu_linefill.sv
// Linefill BIU: queues HTU requests, issues 2-beat reads, assembles lines for the ISU.
module bank_biu_linefill
    import bank_biu_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int MAX_OUTST = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    bank_biu_linefill_if.slave bus
);

    fill_req_t         push_req;
    fill_req_t         head_req;
    logic              fifo_full;
    logic              fifo_empty;
    logic              ar_fire;
    logic              r_fire;
    logic              isu_fire;
    logic [3:0]        outst_cnt;
    ret_state_e        state_q;
    ret_state_e        state_d;
    logic              cap_lo;
    logic              cap_hi;
    logic              err_set;
    logic [LINE_W-1:0] line_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;

    assign push_req = '{addr: bus.htu_biu_req_addr_i, set: bus.htu_biu_req_set_i, way: bus.htu_biu_req_way_i};

    bank_biu_req_fifo #(.DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (bus.htu_biu_req_valid_i),
        .push_data (push_req),
        .pop       (ar_fire),
        .head      (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Arvalid depends only on registered state, so the head stays put until accepted.
    assign bus.htu_biu_req_ready_o = !fifo_full;
    assign bus.biu_mem_arvalid_o   = !fifo_empty && (outst_cnt < 4'(MAX_OUTST));
    assign bus.biu_mem_araddr_o    = head_req.addr;
    assign bus.biu_mem_arid_o      = make_id(head_req.set, head_req.way);
    assign bus.biu_mem_arlen_o     = AR_LEN;
    assign ar_fire                 = bus.biu_mem_arvalid_o && bus.biu_mem_arready_i;

    assign bus.mem_biu_rready_o = (state_q != RET_OUT);
    assign r_fire               = bus.mem_biu_rvalid_i && bus.mem_biu_rready_o;
    assign bus.biu_isu_rvalid_o = (state_q == RET_OUT);
    assign isu_fire             = bus.biu_isu_rvalid_o && bus.biu_isu_rready_i;
    assign bus.biu_isu_rdata_o  = line_q;
    assign bus.biu_isu_rid_o    = id_q;
    assign bus.biu_err_o        = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst_cnt <= 4'd0;
        end else if (ar_fire && !isu_fire) begin
            outst_cnt <= outst_cnt + 4'd1;
        end else if (isu_fire && !ar_fire && (outst_cnt != 4'd0)) begin
            outst_cnt <= outst_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RET_BEAT0;
        else       state_q <= state_d;
    end

    // Protocol errors are flagged but never alter the beat sequence.
    always_comb begin
        state_d = state_q;
        cap_lo  = 1'b0;
        cap_hi  = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            RET_BEAT0: if (r_fire) begin
                cap_lo  = 1'b1;
                err_set = bus.mem_biu_rlast_i;
                state_d = RET_BEAT1;
            end
            RET_BEAT1: if (r_fire) begin
                cap_hi  = 1'b1;
                err_set = !bus.mem_biu_rlast_i || (bus.mem_biu_rid_i != id_q);
                state_d = RET_OUT;
            end
            RET_OUT: if (bus.biu_isu_rready_i) state_d = RET_BEAT0;
            default: state_d = RET_BEAT0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (cap_lo) begin
                line_q[BEAT_W-1:0] <= bus.mem_biu_rdata_i;
                id_q               <= bus.mem_biu_rid_i;
            end
            if (cap_hi)  line_q[LINE_W-1:BEAT_W] <= bus.mem_biu_rdata_i;
            if (err_set) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bank_biu_linefill.sv
// Directed bench for the linefill BIU: request queueing, AR throttling, line assembly and error flag.
module tb_bank_biu_linefill;

    logic clk;
    logic rst;
    int   check_cnt;
    int   err_cnt;
    int   ar_count;

    bank_biu_linefill_if bus();

    bank_biu_linefill #(.REQ_DEPTH(4), .MAX_OUTST(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        check_cnt++;
        assert (observed === expected) else begin
            err_cnt++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] set, input logic [2:0] way, input logic [31:0] addr);
        bus.htu_biu_req_valid_i = 1'b1;
        bus.htu_biu_req_set_i   = set;
        bus.htu_biu_req_way_i   = way;
        bus.htu_biu_req_addr_i  = addr;
        tick();
        bus.htu_biu_req_valid_i = 1'b0;
    endtask

    task automatic driveBeat(input logic [5:0] id, input logic [127:0] data, input logic last);
        bus.mem_biu_rvalid_i = 1'b1;
        bus.mem_biu_rid_i    = id;
        bus.mem_biu_rdata_i  = data;
        bus.mem_biu_rlast_i  = last;
        tick();
        bus.mem_biu_rvalid_i = 1'b0;
        bus.mem_biu_rlast_i  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        bus.htu_biu_req_valid_i = 1'b0;
        bus.htu_biu_req_set_i   = 3'd0;
        bus.htu_biu_req_way_i   = 3'd0;
        bus.htu_biu_req_addr_i  = 32'd0;
        bus.biu_mem_arready_i   = 1'b0;
        bus.mem_biu_rvalid_i    = 1'b0;
        bus.mem_biu_rdata_i     = 128'd0;
        bus.mem_biu_rid_i       = 6'd0;
        bus.mem_biu_rlast_i     = 1'b0;
        bus.biu_isu_rready_i    = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_req_ready", bus.htu_biu_req_ready_o, 1);
        checkOutput("rst_arvalid", bus.biu_mem_arvalid_o, 0);
        checkOutput("rst_isu_rvalid", bus.biu_isu_rvalid_o, 0);
        checkOutput("rst_err", bus.biu_err_o, 0);
        checkOutput("rst_rready", bus.mem_biu_rready_o, 1);
        checkOutput("rst_rdata", bus.biu_isu_rdata_o, 0);
        checkOutput("rst_rid", bus.biu_isu_rid_o, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single linefill");
        applyStimulus(3'd3, 3'd5, 32'h40);
        checkOutput("single_arvalid", bus.biu_mem_arvalid_o, 1);
        checkOutput("single_araddr", bus.biu_mem_araddr_o, 32'h40);
        checkOutput("single_arid", bus.biu_mem_arid_o, 6'h1D);
        checkOutput("single_arlen", bus.biu_mem_arlen_o, 8'd1);
        tick();
        checkOutput("ar_stall_arvalid", bus.biu_mem_arvalid_o, 1);
        checkOutput("ar_stall_araddr", bus.biu_mem_araddr_o, 32'h40);
        bus.biu_mem_arready_i = 1'b1;
        tick();
        bus.biu_mem_arready_i = 1'b0;
        checkOutput("single_ar_done", bus.biu_mem_arvalid_o, 0);
        checkOutput("single_outst1", dut.outst_cnt, 4'd1);
        driveBeat(6'h1D, 128'hA, 1'b0);
        checkOutput("beat0_no_rvalid", bus.biu_isu_rvalid_o, 0);
        driveBeat(6'h1D, 128'hB, 1'b1);
        checkOutput("single_isu_rvalid", bus.biu_isu_rvalid_o, 1);
        checkOutput("single_rdata", bus.biu_isu_rdata_o, {128'hB, 128'hA});
        checkOutput("single_rid", bus.biu_isu_rid_o, 6'h1D);
        checkOutput("single_out_rready", bus.mem_biu_rready_o, 0);
        bus.biu_isu_rready_i = 1'b1;
        tick();
        bus.biu_isu_rready_i = 1'b0;
        checkOutput("single_isu_done", bus.biu_isu_rvalid_o, 0);
        checkOutput("single_outst0", dut.outst_cnt, 4'd0);
        checkOutput("single_err", bus.biu_err_o, 0);

        $display("[TB] ISU backpressure with next beat waiting");
        bus.biu_mem_arready_i = 1'b1;
        applyStimulus(3'd1, 3'd2, 32'h1000);
        applyStimulus(3'd2, 3'd3, 32'h2000);
        tick();
        bus.biu_mem_arready_i = 1'b0;
        checkOutput("bp_ar_drained", bus.biu_mem_arvalid_o, 0);
        checkOutput("bp_outst2", dut.outst_cnt, 4'd2);
        driveBeat(6'h0A, 128'h11, 1'b0);
        driveBeat(6'h0A, 128'h22, 1'b1);
        bus.mem_biu_rvalid_i = 1'b1;
        bus.mem_biu_rid_i    = 6'h13;
        bus.mem_biu_rdata_i  = 128'h33;
        bus.mem_biu_rlast_i  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_isu_rvalid", bus.biu_isu_rvalid_o, 1);
            checkOutput("bp_rready_low", bus.mem_biu_rready_o, 0);
            checkOutput("bp_rdata_stable", bus.biu_isu_rdata_o, {128'h22, 128'h11});
            tick();
        end
        bus.biu_isu_rready_i = 1'b1;
        tick();
        bus.biu_isu_rready_i = 1'b0;
        checkOutput("bp_rready_back", bus.mem_biu_rready_o, 1);
        tick();
        driveBeat(6'h13, 128'h44, 1'b1);
        checkOutput("bp_line2_rvalid", bus.biu_isu_rvalid_o, 1);
        checkOutput("bp_line2_rdata", bus.biu_isu_rdata_o, {128'h44, 128'h33});
        checkOutput("bp_line2_rid", bus.biu_isu_rid_o, 6'h13);
        bus.biu_isu_rready_i = 1'b1;
        tick();
        bus.biu_isu_rready_i = 1'b0;
        checkOutput("bp_outst0", dut.outst_cnt, 4'd0);
        checkOutput("bp_err", bus.biu_err_o, 0);

        $display("[TB] outstanding limit");
        ar_count = 0;
        bus.biu_mem_arready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.htu_biu_req_valid_i = 1'b1;
            bus.htu_biu_req_set_i   = 3'(i);
            bus.htu_biu_req_way_i   = 3'(i >> 1);
            bus.htu_biu_req_addr_i  = 32'(i * 32);
            if (bus.biu_mem_arvalid_o) ar_count++;
            tick();
        end
        bus.htu_biu_req_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.biu_mem_arvalid_o) ar_count++;
            tick();
        end
        checkOutput("lim_ar_count", ar_count, 8);
        checkOutput("lim_arvalid_held", bus.biu_mem_arvalid_o, 0);
        checkOutput("lim_outst8", dut.outst_cnt, 4'd8);
        driveBeat(6'h00, 128'h55, 1'b0);
        driveBeat(6'h00, 128'h66, 1'b1);
        bus.biu_isu_rready_i = 1'b1;
        tick();
        bus.biu_isu_rready_i = 1'b0;
        checkOutput("lim_9th_arvalid", bus.biu_mem_arvalid_o, 1);
        checkOutput("lim_9th_araddr", bus.biu_mem_araddr_o, 32'h100);
        checkOutput("lim_9th_arid", bus.biu_mem_arid_o, 6'h04);
        tick();
        bus.biu_mem_arready_i = 1'b0;
        checkOutput("lim_9th_taken", bus.biu_mem_arvalid_o, 0);
        checkOutput("lim_outst_back8", dut.outst_cnt, 4'd8);

        $display("[TB] protocol errors");
        doReset();
        driveBeat(6'h05, 128'h1, 1'b1);
        checkOutput("err_rlast_beat0", bus.biu_err_o, 1);
        driveBeat(6'h05, 128'h2, 1'b1);
        checkOutput("err_seq_kept", bus.biu_isu_rvalid_o, 1);
        bus.biu_isu_rready_i = 1'b1;
        tick();
        bus.biu_isu_rready_i = 1'b0;
        repeat (3) tick();
        checkOutput("err_sticky", bus.biu_err_o, 1);
        doReset();
        checkOutput("err_cleared", bus.biu_err_o, 0);
        driveBeat(6'h05, 128'h1, 1'b0);
        driveBeat(6'h06, 128'h2, 1'b1);
        checkOutput("err_rid_mismatch", bus.biu_err_o, 1);
        checkOutput("err_mismatch_out", bus.biu_isu_rvalid_o, 1);
        doReset();
        driveBeat(6'h05, 128'h1, 1'b0);
        checkOutput("err_none_yet", bus.biu_err_o, 0);
        driveBeat(6'h05, 128'h2, 1'b0);
        checkOutput("err_no_rlast_beat1", bus.biu_err_o, 1);

        $display("[TB] request FIFO full");
        doReset();
        applyStimulus(3'd1, 3'd1, 32'h20);
        applyStimulus(3'd2, 3'd2, 32'h40);
        applyStimulus(3'd3, 3'd3, 32'h60);
        checkOutput("fifo3_ready", bus.htu_biu_req_ready_o, 1);
        applyStimulus(3'd4, 3'd4, 32'h80);
        checkOutput("fifo_full_ready", bus.htu_biu_req_ready_o, 0);
        checkOutput("fifo_full_arid", bus.biu_mem_arid_o, 6'h09);
        bus.biu_mem_arready_i = 1'b1;
        tick();
        bus.biu_mem_arready_i = 1'b0;
        checkOutput("fifo_pop_ready", bus.htu_biu_req_ready_o, 1);
        checkOutput("fifo_pop_arid", bus.biu_mem_arid_o, 6'h12);
        checkOutput("fifo_pop_araddr", bus.biu_mem_araddr_o, 32'h40);

        $display("[TB] reset mid-burst");
        doReset();
        applyStimulus(3'd5, 3'd6, 32'h300);
        bus.biu_mem_arready_i = 1'b1;
        tick();
        bus.biu_mem_arready_i = 1'b0;
        checkOutput("mid_outst1", dut.outst_cnt, 4'd1);
        driveBeat(6'h2E, 128'hC, 1'b0);
        doReset();
        checkOutput("mid_outst0", dut.outst_cnt, 4'd0);
        checkOutput("mid_rready", bus.mem_biu_rready_o, 1);
        checkOutput("mid_isu_rvalid", bus.biu_isu_rvalid_o, 0);
        checkOutput("mid_rdata", bus.biu_isu_rdata_o, 0);
        checkOutput("mid_rid", bus.biu_isu_rid_o, 0);
        driveBeat(6'h2E, 128'hD, 1'b0);
        checkOutput("mid_beat0_again", bus.biu_isu_rvalid_o, 0);
        checkOutput("mid_no_err", bus.biu_err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
